// File: rtl/cla_adder_sync.sv
// Registered two-level carry-lookahead adder: {cout,sum} = a + b + cin, plus block P/G for cascading.
// Latency: 1 clock from an in_valid edge to out_valid=1 with the result held in output registers.
// No backpressure: accepts one operation every cycle; result registers hold while in_valid=0.
module cla_adder_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             grp_p,
  output logic             grp_g,
  output logic             out_valid
);

  localparam int NG = WIDTH / 4;

  // Second-level lookahead carry into group j, written as a flat sum of products:
  // cin&P[0..j-1] | G[0]&P[1..j-1] | ... | G[j-1]. Every product term is built
  // independently so no carry depends on a previously computed carry.
  function automatic logic la_carry(input logic [NG-1:0] gv,
                                    input logic [NG-1:0] pv,
                                    input logic          ci,
                                    input int            j);
    logic res;
    logic term;
    term = ci;
    for (int m = 0; m < j; m++) term = term & pv[m];
    res = term;
    for (int m = 0; m < j; m++) begin
      term = gv[m];
      for (int n = m + 1; n < j; n++) term = term & pv[n];
      res = res | term;
    end
    return res;
  endfunction

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      gc;
  logic             blk_g;

  assign g = a & b;
  assign p = a ^ b;

  // First level: per 4-bit group, expanded internal carries and group P/G.
  for (genvar k = 0; k < NG; k++) begin : grp
    logic [3:0] gl;
    logic [3:0] pl;
    logic       ci;
    assign gl = g[4*k +: 4];
    assign pl = p[4*k +: 4];
    assign ci = gc[k];

    assign c[4*k]   = ci;
    assign c[4*k+1] = gl[0] | (pl[0] & ci);
    assign c[4*k+2] = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & ci);
    assign c[4*k+3] = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0])
                    | (pl[2] & pl[1] & pl[0] & ci);

    assign gp[k] = &pl;
    assign gg[k] = gl[3] | (pl[3] & gl[2]) | (pl[3] & pl[2] & gl[1])
                 | (pl[3] & pl[2] & pl[1] & gl[0]);
  end

  // Second level: group carry-ins (and the final carry-out at index NG) from group P/G and cin.
  for (genvar j = 0; j <= NG; j++) begin : lvl2
    assign gc[j] = la_carry(gg, gp, cin, j);
  end

  // Block generate ignores cin: the whole word produces a carry on its own.
  assign blk_g = la_carry(gg, gp, 1'b0, NG);

  // Result registers: load on a valid edge, otherwise hold data and drop out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      grp_p     <= 1'b0;
      grp_g     <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      sum       <= p ^ c;
      cout      <= gc[NG];
      grp_p     <= &gp;
      grp_g     <= blk_g;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cla_adder_sync.sv
// Self-checking bench for cla_adder_sync at WIDTH 4, 16 and 32.
// Latency: results checked 1 ns after each rising edge against a queued reference.
// No backpressure exists; stimulus is applied every cycle.
module tb_cla_adder_sync;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // WIDTH=4 instance
  logic       v4 = 1'b0, c4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [3:0] s4;
  logic       co4, gp4, gg4, ov4;
  // WIDTH=16 instance
  logic        v16 = 1'b0, c16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [15:0] s16;
  logic        co16, gp16, gg16, ov16;
  // WIDTH=32 instance
  logic        v32 = 1'b0, c32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [31:0] s32;
  logic        co32, gp32, gg32, ov32;

  // Expected {grp_p, grp_g, cout, sum}
  logic [6:0]  q4[$];
  logic [34:0] q32[$];

  always #5 clk = ~clk;

  cla_adder_sync #(.WIDTH(4)) d4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cin(c4),
    .sum(s4), .cout(co4), .grp_p(gp4), .grp_g(gg4), .out_valid(ov4));

  cla_adder_sync #(.WIDTH(16)) d16 (
    .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .cin(c16),
    .sum(s16), .cout(co16), .grp_p(gp16), .grp_g(gg16), .out_valid(ov16));

  cla_adder_sync #(.WIDTH(32)) d32 (
    .clk(clk), .rst(rst), .in_valid(v32), .a(a32), .b(b32), .cin(c32),
    .sum(s32), .cout(co32), .grp_p(gp32), .grp_g(gg32), .out_valid(ov32));

  task automatic test_reset;
    // Drive a live operation during reset: reset must win.
    v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({s4, co4, gp4, gg4, ov4} !== 8'h00) begin
      errors++;
      $display("FAIL reset_w4 got=%h exp=00", {s4, co4, gp4, gg4, ov4});
    end
    checks++;
    if ({s16, co16, gp16, gg16, ov16} !== 20'h0) begin
      errors++;
      $display("FAIL reset_w16 got=%h exp=0", {s16, co16, gp16, gg16, ov16});
    end
    checks++;
    if ({s32, co32, gp32, gg32, ov32} !== 36'h0) begin
      errors++;
      $display("FAIL reset_w32 got=%h exp=0", {s32, co32, gp32, gg32, ov32});
    end
    // Release with in_valid low: outputs must remain cleared.
    v4 = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({s4, co4, gp4, gg4, ov4} !== 8'h00) begin
      errors++;
      $display("FAIL reset_release got=%h exp=00", {s4, co4, gp4, gg4, ov4});
    end
  endtask

  task automatic test_exhaustive4;
    logic [4:0] t;
    logic [6:0] e;
    for (int i = 0; i < 512; i++) begin
      a4 = i[3:0]; b4 = i[7:4]; c4 = i[8]; v4 = 1'b1;
      t = {1'b0, a4} + {1'b0, b4};
      q4.push_back({&(a4 ^ b4), t[4], t + {4'b0, c4}});
      @(posedge clk);
      #1;
      checks++;
      if (ov4 !== 1'b1 || q4.size() == 0) begin
        errors++;
        $display("FAIL exh4_valid idx=%0d got=%b exp=1 q=%0d", i, ov4, q4.size());
      end else begin
        e = q4.pop_front();
        if ({gp4, gg4, co4, s4} !== e) begin
          errors++;
          $display("FAIL exh4 idx=%0d got=%b exp=%b", i, {gp4, gg4, co4, s4}, e);
        end
      end
    end
    v4 = 1'b0;
    checks++;
    if (q4.size() != 0) begin
      errors++;
      $display("FAIL exh4_drain got=%0d exp=0", q4.size());
    end
  endtask

  task automatic test_example4;
    a4 = 4'b0111; b4 = 4'b0110; c4 = 1'b1; v4 = 1'b1;
    @(posedge clk);
    #1;
    v4 = 1'b0;
    checks++;
    if ({co4, s4} !== 5'b01110) begin
      errors++;
      $display("FAIL example4 got=%b exp=01110", {co4, s4});
    end
  endtask

  task automatic test_carry_boundary;
    a4 = 4'hF; b4 = 4'h0; c4 = 1'b1; v4 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({s4, co4, gp4, gg4, ov4} !== {4'h0, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL boundary_prop got=%b exp=%b", {s4, co4, gp4, gg4, ov4}, 8'b0000_1101);
    end
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    @(posedge clk);
    #1;
    v4 = 1'b0;
    checks++;
    if ({s4, co4, gp4, gg4} !== {4'hF, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL boundary_max got=%b exp=%b", {s4, co4, gp4, gg4}, 7'b1111_101);
    end
  endtask

  task automatic test_cross_group16;
    a16 = 16'hFFFF; b16 = 16'h0001; c16 = 1'b0; v16 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({co16, s16} !== 17'h1_0000) begin
      errors++;
      $display("FAIL cross16_wrap got=%h exp=10000", {co16, s16});
    end
    a16 = 16'h0FFF; b16 = 16'h0001; c16 = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({co16, s16, ov16} !== {17'h0_1000, 1'b1}) begin
      errors++;
      $display("FAIL cross16_mid got=%h exp=%h", {co16, s16, ov16}, {17'h0_1000, 1'b1});
    end
    a16 = 16'h8000; b16 = 16'h8000; c16 = 1'b1;
    @(posedge clk);
    #1;
    v16 = 1'b0;
    checks++;
    if ({gp16, gg16, co16, s16} !== {1'b0, 1'b1, 17'h1_0001}) begin
      errors++;
      $display("FAIL cross16_top got=%h exp=%h", {gp16, gg16, co16, s16}, {1'b0, 1'b1, 17'h1_0001});
    end
  endtask

  task automatic test_reset_mid;
    a4 = 4'b0101; b4 = 4'b0011; c4 = 1'b0; v4 = 1'b1;
    @(posedge clk);
    #1;
    v4 = 1'b0;
    checks++;
    if ({s4, co4, ov4} !== {4'b1000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_load got=%b exp=%b", {s4, co4, ov4}, 6'b100001);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({s4, co4, gp4, gg4, ov4} !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_async got=%h exp=00", {s4, co4, gp4, gg4, ov4});
    end
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({s4, co4, gp4, gg4, ov4} !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_after got=%h exp=00", {s4, co4, gp4, gg4, ov4});
    end
  endtask

  task automatic test_hold;
    a4 = 4'b0010; b4 = 4'b0011; c4 = 1'b1; v4 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({co4, s4, ov4} !== {5'b00110, 1'b1}) begin
      errors++;
      $display("FAIL hold_load got=%b exp=001101", {co4, s4, ov4});
    end
    v4 = 1'b0; a4 = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({co4, s4, ov4} !== {5'b00110, 1'b0}) begin
      errors++;
      $display("FAIL hold_keep got=%b exp=001100", {co4, s4, ov4});
    end
  endtask

  task automatic test_random32;
    logic [32:0] t;
    logic [34:0] e;
    logic        v;
    for (int i = 0; i < 10000; i++) begin
      v = 1'($urandom_range(0, 1));
      a32 = $urandom; b32 = $urandom; c32 = 1'($urandom_range(0, 1)); v32 = v;
      // Occasionally force all-propagate patterns so grp_p is exercised.
      if ($urandom_range(0, 15) == 0) b32 = ~a32;
      if (v) begin
        t = {1'b0, a32} + {1'b0, b32};
        q32.push_back({&(a32 ^ b32), t[32], t + {32'b0, c32}});
      end
      @(posedge clk);
      #1;
      checks++;
      if (ov32 !== v) begin
        errors++;
        $display("FAIL rand32_valid idx=%0d got=%b exp=%b", i, ov32, v);
      end else if (v) begin
        if (q32.size() == 0) begin
          errors++;
          $display("FAIL rand32_empty idx=%0d got=valid exp=queued", i);
        end else begin
          e = q32.pop_front();
          if ({gp32, gg32, co32, s32} !== e) begin
            errors++;
            $display("FAIL rand32 idx=%0d got=%h exp=%h", i, {gp32, gg32, co32, s32}, e);
          end
        end
      end
    end
    v32 = 1'b0;
    checks++;
    if (q32.size() != 0) begin
      errors++;
      $display("FAIL rand32_drain got=%0d exp=0", q32.size());
    end
  endtask

  initial begin
    test_reset;
    test_exhaustive4;
    test_example4;
    test_carry_boundary;
    test_cross_group16;
    test_reset_mid;
    test_hold;
    test_random32;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_adder_sync.md
Name: cla_adder_sync

Overview:
- Registered carry-lookahead adder: computes sum = a + b + cin and carry-out using two-level lookahead. Does not ripple carries.
- Arithmetic leaf in the ALU datapath. Operands are sampled on a clock edge; the result is held in output registers.
- Default width is 4 bits. Wider instances tile 4-bit lookahead groups under a second-level lookahead unit.

Parameters:
- WIDTH, 4, operand/sum width in bits. Must be a multiple of 4, range 4..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  qualifies a, b, cin this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in.
- sum  output  WIDTH  registered sum, low WIDTH bits.
- cout  output  1  registered carry-out of the MSB.
- grp_p  output  1  registered block propagate (all bits propagate), for cascading.
- grp_g  output  1  registered block generate, for cascading.
- out_valid  output  1  result registers hold a fresh result.

Behaviour:
- Reset: while rst=1, immediately and independent of clk, sum=0, cout=0, grp_p=0, grp_g=0, out_valid=0. Registers stay cleared until the first rising edge after rst deasserts.
- Per bit: g[i]=a[i]&b[i], p[i]=a[i]^b[i].
- Group (4 bits, k=0..3):
  - c[k+1] = g[k] | p[k]&c[k], fully expanded into sum-of-products of g/p and the group carry-in. No chained dependency.
  - Group P = p0&p1&p2&p3; group G = g3|p3g2|p3p2g1|p3p2p1g0.
- Second level: group carry-ins are computed from group P/G and cin with the same expanded lookahead equations.
- Outputs:
  - sum[i] = p[i]^c[i]; cout = carry out of the top group.
  - grp_p/grp_g = AND of all group P / lookahead-combined group G.
- Invariant: {cout,sum} == a + b + cin exactly, for all inputs. Maximum = 2*(2^WIDTH-1)+1, which gives cout=1 and sum=all ones.
- Latency: exactly 1 clock. On each rising edge with in_valid=1, the result of the a/b/cin sampled at that edge is loaded and out_valid=1.
- If in_valid=0 at an edge: sum/cout/grp_p/grp_g hold their previous values and out_valid drops to 0.
- Back-to-back: one new operation per cycle, no stall, no backpressure.
- Reset mid-operation: asserting rst discards any pending result; after release, outputs stay 0 until the next valid edge.
- Wrap-around: a carry out of the MSB never alters sum. Only cout reflects it.
- Unknown inputs: no requirement; the bench drives known values only.
- The critical path contains no ripple carry chain longer than one group's expanded equations plus the second-level unit.

Test Plan:
- WIDTH=4, exhaustive: all 512 combinations of a, b (0..15) and cin, one per cycle with in_valid=1 → each cycle after the edge, {cout,sum} == a+b+cin. Example: a=0111, b=0110, cin=1 gives sum=1110, cout=0.
- WIDTH=4, carry boundary: a=1111, b=0000, cin=1 → sum=0000, cout=1, grp_p=1, grp_g=0. Then a=1111, b=1111, cin=1 → sum=1111, cout=1, grp_g=1.
- WIDTH=16, cross-group lookahead: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1. Then a=0x0FFF, b=0x0001, cin=0 → sum=0x1000, cout=0.
- Reset: load a=0101, b=0011, cin=0, then assert rst asynchronously mid-cycle → sum=0, cout=0, out_valid=0 immediately. After release with in_valid=0 at the next edge, outputs remain 0.
- Hold: load a=0010, b=0011, cin=1 (sum=0110), then drive in_valid=0 with a=1111 → sum stays 0110, out_valid=0.
- Random: WIDTH=32, 10,000 random a/b/cin with in_valid toggling randomly → every out_valid=1 cycle matches the 33-bit reference sum.
